// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared state encoding, pattern modes and LFSR helpers for the
// memory traffic generator/checker.
package mem_test_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} mt_state_e;

    localparam logic [1:0] MT_CONST = 2'd0;
    localparam logic [1:0] MT_ADDR  = 2'd1;
    localparam logic [1:0] MT_WALK  = 2'd2;
    localparam logic [1:0] MT_LFSR  = 2'd3;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic ASSERT_L = 1'b0;
    localparam logic ASSERT_H = 1'b1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
endpackage

// File: rtl/mem_patt_gen.sv
// mem_patt_gen: per-word test pattern source; patt is the look-ahead value for the
// word selected after this cycle's init/step, so callers can register it directly.
module mem_patt_gen
    import mem_test_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 24,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_patt,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [DATA_W-1:0] patt
);
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] const_q, const_d, walk_q, walk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [63:0]       addr_ext;

    always_comb begin
        mode_d   = init ? mode : mode_q;
        const_d  = init ? const_patt : const_q;
        addr_d   = init ? base_addr : step ? addr_q + ADDR_W'(1) : addr_q;
        walk_d   = init ? DATA_W'(1) : step ? ((walk_q << 1) | (walk_q >> (DATA_W - 1))) : walk_q;
        lfsr_d   = init ? LFSR_SEED : step ? lfsr_next(lfsr_q) : lfsr_q;
        addr_ext = 64'(addr_d);
        patt     = (mode_d == MT_CONST) ? const_d :
                   (mode_d == MT_ADDR)  ? addr_ext[DATA_W-1:0] :
                   (mode_d == MT_WALK)  ? walk_d : lfsr_d[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (reset == ASSERT_L) begin
            mode_q  <= MT_CONST;
            const_q <= '0;
            addr_q  <= '0;
            walk_q  <= DATA_W'(1);
            lfsr_q  <= LFSR_SEED;
        end else begin
            mode_q  <= mode_d;
            const_q <= const_d;
            addr_q  <= addr_d;
            walk_q  <= walk_d;
            lfsr_q  <= lfsr_d;
        end
    end
endmodule

// File: rtl/mem_test_gen.sv
// mem_test_gen: writes a pattern over an address window, reads it back in order,
// and reports pass/fail, miscompare count, first failing address and error flags.
module mem_test_gen
    import mem_test_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 24,
    parameter logic [31:0] CMP_MASK  = 32'h00FF_FFFF,
    parameter int          MAX_OUT   = 8,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] const_patt,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              wr_rdy,
    input  logic              rd_rdy,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout_err,
    output logic              unexp_err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] MASK = CMP_MASK[DATA_W-1:0];

    mt_state_e         state_q, state_d;
    logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d;
    logic              pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, unexp_q, unexp_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, chk_addr_q, chk_addr_d;
    logic [ADDR_W-1:0] first_q, first_d, wrem_q, wrem_d, rrem_q, rrem_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, exp_q, exp_d, wpatt, cpatt;
    logic [15:0]       err_q, err_d;
    logic [OW-1:0]     out_q, out_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              start_ok, wr_acc, rd_acc, chk, stray, miss, idle_wait, tmo_fire, fin, bad;

    mem_patt_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LFSR_SEED(LFSR_SEED)) u_wgen (
        .clk(clk), .reset(reset), .init(start_ok), .step(wr_acc), .mode(mode),
        .const_patt(const_patt), .base_addr(base_addr), .patt(wpatt)
    );

    mem_patt_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LFSR_SEED(LFSR_SEED)) u_cgen (
        .clk(clk), .reset(reset), .init(start_ok), .step(chk), .mode(mode),
        .const_patt(const_patt), .base_addr(base_addr), .patt(cpatt)
    );

    always_comb begin
        start_ok  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
        // a strobe only counts when the port was also ready in that cycle; otherwise it is re-issued
        wr_acc    = wr_en_q & wr_rdy;
        rd_acc    = rd_en_q & rd_rdy;
        chk       = rd_data_valid & ((state_q == ST_READ) | (state_q == ST_DRAIN)) & (out_q != '0);
        stray     = rd_data_valid & ~chk;
        miss      = chk & (((rd_data ^ exp_q) & MASK) != '0);
        idle_wait = (state_q == ST_DRAIN) & (out_q != '0) & ~rd_data_valid;
        tmo_fire  = idle_wait & (tcnt_q == TW'(TIMEOUT - 1));
        tcnt_d    = idle_wait ? tcnt_q + TW'(1) : '0;
        wrem_d    = start_ok ? length : wrem_q - ADDR_W'(wr_acc);
        rrem_d    = start_ok ? length : rrem_q - ADDR_W'(rd_acc);
        out_d     = start_ok ? '0 : out_q + OW'(rd_acc) - OW'(chk);
        state_d   = start_ok ? ((length == '0) ? ST_DONE : ST_WRITE) :
                    ((state_q == ST_WRITE) && (wrem_d == '0)) ? ST_READ :
                    ((state_q == ST_READ) && (rrem_d == '0)) ? ST_DRAIN :
                    ((state_q == ST_DRAIN) && ((out_d == '0) || tmo_fire)) ? ST_DONE : state_q;
        wr_en_d    = (state_d == ST_WRITE) & wr_rdy;
        rd_en_d    = (state_d == ST_READ) & rd_rdy & (out_d < OW'(MAX_OUT));
        wr_addr_d  = start_ok ? base_addr : wr_addr_q + ADDR_W'(wr_acc);
        rd_addr_d  = start_ok ? base_addr : rd_addr_q + ADDR_W'(rd_acc);
        chk_addr_d = start_ok ? base_addr : chk_addr_q + ADDR_W'(chk);
        wr_data_d  = (start_ok | wr_acc) ? wpatt : wr_data_q;
        exp_d      = (start_ok | chk) ? cpatt : exp_q;
        err_d      = start_ok ? '0 : err_q + 16'(miss & (err_q != 16'hFFFF));
        first_d    = start_ok ? '0 : (miss & (err_q == '0)) ? chk_addr_q : first_q;
        tmo_d      = start_ok ? 1'b0 : tmo_q | tmo_fire;
        // a stray strobe seen in IDLE survives into the next run's verdict
        unexp_d    = ((start_ok & (state_q == ST_DONE)) ? 1'b0 : unexp_q) | stray;
        busy_d     = (state_d == ST_WRITE) | (state_d == ST_READ) | (state_d == ST_DRAIN);
        done_d     = state_d == ST_DONE;
        fin        = done_d & ((state_q != ST_DONE) | start_ok);
        bad        = (err_d != '0) | tmo_d | unexp_d;
        fail_d     = fin ? bad : done_d & fail_q;
        pass_d     = fin ? ~bad : done_d & pass_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (reset == ASSERT_L) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tmo_q      <= 1'b0;
            unexp_q    <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            chk_addr_q <= '0;
            first_q    <= '0;
            wrem_q     <= '0;
            rrem_q     <= '0;
            wr_data_q  <= '0;
            exp_q      <= '0;
            err_q      <= '0;
            out_q      <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            tmo_q      <= tmo_d;
            unexp_q    <= unexp_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            chk_addr_q <= chk_addr_d;
            first_q    <= first_d;
            wrem_q     <= wrem_d;
            rrem_q     <= rrem_d;
            wr_data_q  <= wr_data_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
            out_q      <= out_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign rd_en          = rd_en_q;
    assign wr_addr        = wr_addr_q;
    assign rd_addr        = rd_addr_q;
    assign wr_data        = wr_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign timeout_err    = tmo_q;
    assign unexp_err      = unexp_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
endmodule

// File: tb/tb_mem_test_gen.sv
// tb_mem_test_gen: scoreboard bench; runs push expected writes, reads and final
// status, and monitors pop and compare as the DUT presents them.
module tb_mem_test_gen;
    localparam int DW = 32;
    localparam int AW = 24;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, wr_rdy = 1'b1, rd_rdy = 1'b1, rd_data_valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [DW-1:0] const_patt = '0, rd_data = '0, wr_data;
    logic [AW-1:0] base_addr = '0, length = '0, wr_addr, rd_addr, first_err_addr;
    logic wr_en, rd_en, busy, done, pass, fail, timeout_err, unexp_err;
    logic [15:0] err_count;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic p; logic f; logic t; logic u; logic [15:0] e; logic [AW-1:0] fa; } st_t;
    typedef struct { logic [31:0] d; int due; } rsp_t;

    wr_t exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    st_t exp_st[$];
    rsp_t rsp_q[$];
    logic [31:0] mem [int];

    int total = 0, bad = 0;
    int cyc = 0, outst = 0, max_out = 0, rd_seen = 0, fixed_lat = 3, drop_idx = -1;
    bit rand_rdy = 0, rand_lat = 0, flip = 0, drop = 0, spur = 0;
    logic done_prev = 1'b0;
    wr_t mw;
    st_t ms;
    rsp_t rsp;
    logic [31:0] rd_word;

    always #5 clk = ~clk;

    mem_test_gen dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .const_patt(const_patt),
        .base_addr(base_addr), .length(length), .wr_rdy(wr_rdy), .rd_rdy(rd_rdy),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .timeout_err(timeout_err), .unexp_err(unexp_err),
        .err_count(err_count), .first_err_addr(first_err_addr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {wr_en, rd_en, busy, done, pass, fail, timeout_err, unexp_err}, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_err_addr"}, first_err_addr, 0);
        chk({tag, "_addrs"}, {wr_addr, rd_addr}, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
    endtask

    // RAM model: in-order echo memory with configurable latency and fault injection
    initial forever begin
        @(negedge clk);
        if (reset && wr_en && wr_rdy) mem[int'(wr_addr)] = wr_data;
        if (reset && rd_en && rd_rdy) begin
            rd_word = mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : 32'h0;
            if (flip && rd_addr == 24'h00000A) rd_word = rd_word ^ 32'h20;
            if (!(drop && rd_seen == drop_idx)) begin
                rsp.d = rd_word;
                rsp.due = cyc + (rand_lat ? int'($urandom_range(1, 20)) : fixed_lat);
                rsp_q.push_back(rsp);
            end
            rd_seen++;
        end
        @(posedge clk);
        #1;
        cyc++;
        rd_data_valid = 1'b0;
        if (!reset) rsp_q.delete();
        else if (spur) begin
            rd_data_valid = 1'b1;
            rd_data = '0;
            spur = 0;
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            rsp = rsp_q.pop_front();
            rd_data_valid = 1'b1;
            rd_data = rsp.d;
        end
        wr_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        rd_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // monitor: compares accepted requests and final status against the queues
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            done_prev = 1'b0;
        end else begin
            if (wr_en && wr_rdy) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mw = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, mw.a);
                    chk("wr_data", wr_data, mw.d);
                end
            end
            if (rd_en && rd_rdy) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", rd_addr, exp_rd.pop_front());
                outst++;
                if (outst > max_out) max_out = outst;
            end
            if (rd_data_valid && outst > 0) outst--;
            if (start) done_prev = 1'b0;
            else begin
                if (done && !done_prev) begin
                    if (exp_st.size() == 0) chk("done_unexpected", 1, 0);
                    else begin
                        ms = exp_st.pop_front();
                        chk("pass", pass, ms.p);
                        chk("fail", fail, ms.f);
                        chk("timeout_err", timeout_err, ms.t);
                        chk("unexp_err", unexp_err, ms.u);
                        chk("err_count", err_count, ms.e);
                        chk("first_err_addr", first_err_addr, ms.fa);
                        chk("busy_at_done", busy, 0);
                        chk("writes_left", exp_wr.size(), 0);
                        chk("reads_left", exp_rd.size(), 0);
                        chk("max_outstanding_le_8", max_out <= 8, 1);
                    end
                end
                done_prev = done;
            end
        end
    end

    task automatic kick(input logic [1:0] m, input logic [31:0] cp, input logic [AW-1:0] b,
                        input logic [AW-1:0] n, input logic ep, input logic ef, input logic et,
                        input logic eu, input logic [15:0] ee, input logic [AW-1:0] efa);
        logic [31:0] l, d;
        logic [AW-1:0] a;
        st_t s;
        l = 32'hACE12345;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            d = (m == 2'd0) ? cp : (m == 2'd1) ? 32'(a) : (m == 2'd2) ? (32'h1 << (i % 32)) : l;
            exp_wr.push_back('{a, d});
            exp_rd.push_back(a);
            l = {1'b0, l[31:1]} ^ ({32{l[0]}} & 32'h80200003);
        end
        s.p = ep; s.f = ef; s.t = et; s.u = eu; s.e = ee; s.fa = efa;
        exp_st.push_back(s);
        rd_seen = 0; outst = 0; max_out = 0;
        mem.delete();
        @(posedge clk);
        #1;
        mode = m; const_patt = cp; base_addr = b; length = n; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, done, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        reset = 1'b1;

        kick(2'd0, 32'h00FFFFFF, 24'h000000, 24'd8, 1, 0, 0, 0, 16'd0, 24'h0);
        wait_done("const_done", 200);

        rand_rdy = 1; rand_lat = 1;
        kick(2'd3, 32'h0, 24'h000100, 24'd256, 1, 0, 0, 0, 16'd0, 24'h0);
        wait_done("lfsr_done", 20000);
        rand_rdy = 0; rand_lat = 0;

        flip = 1;
        kick(2'd1, 32'h0, 24'h000000, 24'd16, 0, 1, 0, 0, 16'd1, 24'h00000A);
        wait_done("flip_done", 300);
        flip = 0;

        kick(2'd2, 32'h0, 24'hFFFFFE, 24'd4, 1, 0, 0, 0, 16'd0, 24'h0);
        wait_done("wrap_done", 200);

        drop = 1; drop_idx = 3;
        kick(2'd0, 32'h5A5A5A5A, 24'h000100, 24'd4, 0, 1, 1, 0, 16'd0, 24'h0);
        wait_done("timeout_done", 3000);
        drop = 0; drop_idx = -1;

        kick(2'd0, 32'h12345678, 24'h000010, 24'd0, 1, 0, 0, 0, 16'd0, 24'h0);
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_pass", pass, 1);
        repeat (5) @(negedge clk);

        kick(2'd0, 32'h00C0FFEE, 24'h000200, 24'd64, 1, 0, 0, 0, 16'd0, 24'h0);
        n = 0;
        while (!rd_en && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_read", rd_en, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("midrun_reset");
        repeat (3) @(posedge clk);
        exp_wr.delete(); exp_rd.delete(); exp_st.delete(); rsp_q.delete();
        outst = 0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        spur = 1;
        repeat (4) @(negedge clk);
        chk("spur_unexp_err", unexp_err, 1);
        chk("spur_not_done", done, 0);
        kick(2'd1, 32'h0, 24'h000040, 24'd8, 0, 1, 0, 1, 16'd0, 24'h0);
        wait_done("spur_run_done", 200);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_test_gen.md
# mem_test_gen

Parametrised memory traffic generator and checker for one port of the 4-port RAM interface. On a start pulse it writes a configurable pattern over an address window, reads the window back, compares every returned word in order, and reports pass/fail, error count and first failing address. It replaces the fixed constant-pattern test logic in the capture top level and adds four pattern modes, outstanding-read tracking, a drain timeout and error capture.

## Interface
- `DATA_W`, 32: width of `wr_data`/`rd_data`, 1..32.
- `ADDR_W`, 24: width of address ports.
- `CMP_MASK`, 32'h00FF_FFFF: bits compared; other bits ignored. Only the low `DATA_W` bits are used.
- `MAX_OUT`, 8: maximum reads in flight, power of two, 2..64.
- `TIMEOUT`, 1024: maximum cycles without `rd_data_valid` while reads are outstanding.
- `LFSR_SEED`, 32'hACE1_2345: LFSR start value. Must be nonzero.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that starts a run. Honoured only in IDLE or DONE.
- `mode` in 2: 0 constant `const_patt`, 1 address-as-data, 2 walking ones, 3 LFSR. Latched on `start`.
- `const_patt` in DATA_W: data for mode 0. Latched on `start`.
- `base_addr` in ADDR_W: first address. Latched on `start`.
- `length` in ADDR_W: number of words. Latched on `start`.
- `wr_rdy`, `rd_rdy` in 1: the port accepts a write or read this cycle.
- `rd_data_valid` in 1: one-cycle strobe; `rd_data` is valid in that cycle.
- `rd_data` in DATA_W: read return data, in request order.
- `wr_en`, `rd_en` out 1: one-cycle request strobes.
- `wr_addr`, `rd_addr` out ADDR_W: request addresses.
- `wr_data` out DATA_W: write data.
- `busy`, `done`, `pass`, `fail` out 1: run status.
- `timeout_err`, `unexp_err` out 1: sticky error flags.
- `err_count` out 16: number of miscompares; saturates at 16'hFFFF.
- `first_err_addr` out ADDR_W: address of the first miscompare.

## Operation
- States:
  - IDLE → WRITE on `start`. If `length` = 0, IDLE → DONE with `pass` = 1.
  - WRITE → READ after `length` writes have been issued.
  - READ → DRAIN after `length` reads have been issued.
  - DRAIN → DONE when the outstanding count reaches 0, or when the timeout fires.
  - DONE → WRITE on `start`. This clears all status and error outputs.
- WRITE:
  - Assert `wr_en` only in a cycle where `wr_rdy` = 1.
  - `wr_addr` = `base_addr` + i, where i = 0..`length`-1. Addresses wrap modulo 2^ADDR_W.
- READ:
  - Assert `rd_en` only when `rd_rdy` = 1 and outstanding < `MAX_OUT`.
  - `rd_addr` follows the same sequence as `wr_addr`.
- Outstanding counter:
  - +1 on `rd_en`, -1 on `rd_data_valid`.
  - When both occur in the same cycle, the count is unchanged.
- Pattern for word i:
  - Mode 0: `const_patt`.
  - Mode 1: (`base_addr` + i), zero-extended or truncated to `DATA_W`.
  - Mode 2: `1 << (i mod DATA_W)`.
  - Mode 3: 32-bit Galois LFSR, taps 32'h8020_0003, starting at `LFSR_SEED` and stepped once per word. Data is the low `DATA_W` bits.
- Checker:
  - Uses a second, independent generator that advances only on `rd_data_valid`.
  - Compare: ((`rd_data` ^ expected) & `CMP_MASK`) != 0.
  - The first miscompare latches `first_err_addr`.
- `rd_data_valid` in IDLE, WRITE or DONE, or with outstanding = 0: set `unexp_err` and do not compare.
- DRAIN timeout: `TIMEOUT` consecutive cycles with outstanding > 0 and no valid → set `timeout_err` and go to DONE.
- On entry to DONE:
  - `fail` = (`err_count` != 0) | `timeout_err` | `unexp_err`.
  - `pass` = !`fail`.
- A `start` pulse while `busy` is ignored.
- `reset` asserted mid-run aborts immediately. No partial-state recovery.

## Timing
- Reset values:
  - All outputs 0, including `wr_en`, `rd_en`, `busy`, `done`, `pass` and `fail`.
  - State IDLE; LFSRs at `LFSR_SEED`.
- `busy` is 1 in WRITE, READ and DRAIN.
- `done`, `pass` and `fail` are registered levels that hold until the next `start`.
- `start` at cycle t: the first `wr_en` can appear at t+1.
- Best-case throughput is one request per cycle when `wr_rdy`/`rd_rdy` are held high.
- No gap cycle between the last write and the first read.
- Checker result is registered: `err_count` updates one cycle after `rd_data_valid`.
- The final compare is reflected in `pass`/`fail` when `done` rises.
- `rd_data_valid` latency from `rd_en` is arbitrary, ≥ 1 cycle.
- All outputs are registered. No combinational path from `*_rdy` to `*_en`.
  - The generator samples `*_rdy` and asserts `*_en` on the next edge, with the request held valid only while `*_rdy` stays high.
  - The RAM port must tolerate `*_en` asserted in a cycle where `*_rdy` has just dropped. The generator re-issues any request not accepted under that rule.

## Structure
- The shared package `mem_test_pkg` holds:
  - The state enum.
  - Mode encodings `MT_CONST`, `MT_ADDR`, `MT_WALK`, `MT_LFSR`.
  - `LFSR_TAPS`.
  - The `ASSERT_L`/`ASSERT_H` level constants.
- One sub-module, `mem_patt_gen`, computes the pattern for word i.
  - Inputs: `mode`, `const_patt`, `base_addr`.
  - Controls: `init` and `step`.
  - Output: `patt`.
  - It is instantiated twice: once for the write side and once for the checker.

## Test plan
- Mode 0, `const_patt` = 24'hFFFFFF, `base_addr` = 0, `length` = 8, ideal echo RAM with 3-cycle latency: 8 writes then 8 reads → `pass` = 1, `err_count` = 0.
- Mode 3, `length` = 256, random `wr_rdy`/`rd_rdy`, random latency 1..20: outstanding never exceeds 8 → `pass` = 1.
- Mode 1, `length` = 16, RAM flips bit 5 at address 0x00000A: `err_count` = 1, `first_err_addr` = 0x00000A, `fail` = 1.
- Mode 2, `base_addr` = 24'hFFFFFE, `length` = 4: addresses FFFFFE, FFFFFF, 000000, 000001 → pass.
- RAM drops the last read response: `timeout_err` = 1 after 1024 idle cycles, `fail` = 1. Separately, a spurious `rd_data_valid` in IDLE then a good run → `unexp_err` = 1, `fail` = 1.
- `length` = 0 → `done` = 1 and `pass` = 1 within 1 cycle, no requests issued. Separately, `reset` pulsed mid-READ → all outputs return to 0.
